// File: rtl/sopc_timer_sched.sv
// Shares one interval timer between NUM_REQ requesters: round-robin grant, programs the
// timer over its 16-bit slave port, waits for irq (or abort) and pulses done to the winner.
module sopc_timer_sched #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  req_period,
    input  logic                   abort,
    output logic [NUM_REQ-1:0]     done,
    output logic                   aborted,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_idx,
    output logic [2:0]             tmr_address,
    output logic                   tmr_chipselect,
    output logic                   tmr_write_n,
    output logic [15:0]            tmr_writedata,
    input  logic                   tmr_irq
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WR_PL  = 4'd1;
    localparam logic [3:0] S_WR_PH  = 4'd2;
    localparam logic [3:0] S_WR_ST  = 4'd3;
    localparam logic [3:0] S_WR_CTL = 4'd4;
    localparam logic [3:0] S_WAIT   = 4'd5;
    localparam logic [3:0] S_STOP   = 4'd6;
    localparam logic [3:0] S_CLR    = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    logic [3:0]         r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [31:0]        r_period;
    logic               r_abort_pend;
    logic               r_abort_flag;
    logic               r_mask_vld;

    logic [NUM_REQ-1:0] w_req_m;
    logic               w_gnt_vld;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [31:0]        w_period;

    // Cyclic search from rr_ptr; walking downward lets the closest candidate win.
    always_comb begin
        w_req_m = req;
        if (r_mask_vld) begin
            w_req_m[r_grant_idx] = 1'b0;
        end
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int j;
            j = int'(r_rr_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (w_req_m[IDX_W'(j)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IDX_W'(j);
            end
        end
        w_period = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == w_gnt_idx) begin
                w_period = req_period[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_grant_idx  <= '0;
            r_period     <= '0;
            r_abort_pend <= 1'b0;
            r_abort_flag <= 1'b0;
            r_mask_vld   <= 1'b0;
        end else begin
            r_mask_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_grant_idx  <= w_gnt_idx;
                        r_period     <= (w_period == 32'd0) ? 32'd1 : w_period;
                        r_abort_flag <= 1'b0;
                        r_state      <= S_WR_PL;
                    end
                end
                S_WR_PL, S_WR_PH, S_WR_ST, S_WR_CTL: begin
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    r_state <= r_state + 4'd1;
                end
                S_WAIT: begin
                    if (tmr_irq) begin
                        r_state <= S_CLR;
                    end else if (r_abort_pend || abort) begin
                        r_abort_flag <= 1'b1;
                        r_state      <= S_STOP;
                    end
                end
                S_STOP: r_state <= S_CLR;
                S_CLR:  r_state <= S_DONE;
                S_DONE: begin
                    r_rr_ptr     <= (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                         : r_grant_idx + 1'b1;
                    r_abort_pend <= 1'b0;
                    r_mask_vld   <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus and status outputs depend on registered state only.
    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        case (r_state)
            S_WR_PL: begin
                tmr_address   = 3'd2;
                tmr_writedata = r_period[15:0];
            end
            S_WR_PH: begin
                tmr_address   = 3'd3;
                tmr_writedata = r_period[31:16];
            end
            S_WR_CTL: begin
                tmr_address   = 3'd1;
                tmr_writedata = 16'h0005;
            end
            S_STOP: begin
                tmr_address   = 3'd1;
                tmr_writedata = 16'h0008;
            end
            default: ;
        endcase
        if (r_state inside {S_WR_PL, S_WR_PH, S_WR_ST, S_WR_CTL, S_STOP, S_CLR}) begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
        end
        done      = (r_state == S_DONE) ? (NUM_REQ'(1) << r_grant_idx) : '0;
        aborted   = (r_state == S_DONE) && r_abort_flag;
        busy      = (r_state != S_IDLE);
        grant_idx = r_grant_idx;
    end

endmodule

// File: tb/tb_sopc_timer_sched.sv
// Self-checking bench for sopc_timer_sched: directed scenarios then random transactions,
// each checked cycle by cycle against a transaction-level model of the scheduler.
module tb_sopc_timer_sched;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   req;
    logic [127:0] req_period;
    logic         abort;
    logic [3:0]   done;
    logic         aborted;
    logic         busy;
    logic [1:0]   grant_idx;
    logic [2:0]   tmr_address;
    logic         tmr_chipselect;
    logic         tmr_write_n;
    logic [15:0]  tmr_writedata;
    logic         tmr_irq;

    int total = 0;
    int bad   = 0;
    int m_rr   = 0;   // model round-robin pointer
    int m_last = -1;  // index served just before this IDLE cycle, -1 if none

    sopc_timer_sched #(.NUM_REQ(4), .IDX_W(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_period     (req_period),
        .abort          (abort),
        .done           (done),
        .aborted        (aborted),
        .busy           (busy),
        .grant_idx      (grant_idx),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected bus: a write when wr=1, otherwise the idle pattern.
    task automatic chk_bus(input string tag, input logic wr, input logic [2:0] a,
                           input logic [15:0] d);
        chk({tag, "_bus"}, {11'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
            {11'd0, wr, ~wr, wr ? a : 3'd0, wr ? d : 16'd0});
    endtask

    task automatic chk_stat(input string tag, input logic [3:0] d, input logic ab,
                            input logic bz);
        chk({tag, "_stat"}, {26'd0, done, aborted, busy}, {26'd0, d, ab, bz});
    endtask

    function automatic int pick(input logic [3:0] v);
        int i;
        for (int k = 0; k < 4; k++) begin
            i = (m_rr + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic idle_cycle(input logic ab);
        req   = 4'b0000;
        abort = ab;
        chk_stat("idle", 4'b0000, 1'b0, 1'b0);
        step();
        abort  = 1'b0;
        m_last = -1;
    endtask

    // mode: 0 = irq ends the delay, 1 = abort in WAIT, 2 = irq and abort together.
    // abort_wr: -1 none, 0..3 pulses abort during WR_PL..WR_CTL.
    task automatic txn(input logic [3:0] reqv, input int wait_n, input int mode,
                       input int abort_wr);
        int          g;
        logic [31:0] p;
        logic [3:0]  msk;
        logic        ab_exp;
        req = reqv;
        chk_stat("idle0", 4'b0000, 1'b0, 1'b0);
        msk = (m_last >= 0) ? 4'(1 << m_last) : 4'b0000;
        g = pick(reqv & ~msk);
        if (g < 0) begin
            step();
            chk_stat("masked_idle", 4'b0000, 1'b0, 1'b0);
            g = pick(reqv);
        end
        m_last = -1;
        p = req_period[32*g +: 32];
        if (p == 32'd0) p = 32'd1;

        step();
        chk_bus("wr_pl", 1'b1, 3'd2, p[15:0]);
        chk("grant", {30'd0, grant_idx}, g);
        chk_stat("wr_pl", 4'b0000, 1'b0, 1'b1);
        abort = (abort_wr == 0);
        step();
        chk_bus("wr_ph", 1'b1, 3'd3, p[31:16]);
        abort = (abort_wr == 1);
        step();
        chk_bus("wr_st", 1'b1, 3'd0, 16'h0000);
        abort = (abort_wr == 2);
        step();
        chk_bus("wr_ctl", 1'b1, 3'd1, 16'h0005);
        abort = (abort_wr == 3);
        step();
        abort  = 1'b0;
        ab_exp = (abort_wr >= 0) || (mode == 1);
        if (abort_wr < 0) begin
            for (int k = 0; k < wait_n; k++) begin
                chk_bus("wait", 1'b0, 3'd0, 16'h0000);
                chk_stat("wait", 4'b0000, 1'b0, 1'b1);
                step();
            end
            tmr_irq = (mode != 1);
            abort   = (mode != 0);
        end
        chk_bus("wait_last", 1'b0, 3'd0, 16'h0000);
        step();
        abort = 1'b0;
        if (ab_exp) begin
            chk_bus("stop", 1'b1, 3'd1, 16'h0008);
            step();
        end
        chk_bus("clr", 1'b1, 3'd0, 16'h0000);
        chk_stat("clr", 4'b0000, 1'b0, 1'b1);
        tmr_irq = 1'b0;
        abort   = (mode == 0);  // late abort must be ignored
        step();
        abort = 1'b0;
        chk_bus("done", 1'b0, 3'd0, 16'h0000);
        chk_stat("done", 4'(1 << g), ab_exp, 1'b1);
        m_rr   = (g + 1) % 4;
        m_last = g;
        step();
    endtask

    task automatic set_per(input int i, input logic [31:0] v);
        req_period[32*i +: 32] = v;
    endtask

    initial begin
        reset_n    = 1'b0;
        req        = 4'b0000;
        req_period = '0;
        abort      = 1'b0;
        tmr_irq    = 1'b0;
        step();
        step();
        chk_bus("reset", 1'b0, 3'd0, 16'h0000);
        chk_stat("reset", 4'b0000, 1'b0, 1'b0);
        chk("reset_grant", {30'd0, grant_idx}, 32'd0);
        reset_n = 1'b1;

        // Round robin with all requesters held: 0,1,2,3,0.
        for (int i = 0; i < 4; i++) set_per(i, 32'h0000_0010 + i);
        for (int n = 0; n < 5; n++) txn(4'b1111, 1, 0, -1);
        // Requester 0 alone again right after its DONE: masked for one IDLE cycle.
        txn(4'b0001, 0, 0, -1);

        idle_cycle(1'b1);
        set_per(1, 32'h0001_0003);
        txn(4'b0010, 2, 0, -1);
        set_per(2, 32'h1234_5678);
        txn(4'b0100, 1, 1, -1);
        set_per(3, 32'h0000_0100);
        txn(4'b1000, 0, 0, 1);
        set_per(0, 32'h0000_0000);
        txn(4'b0001, 0, 2, -1);

        // Reset during WAIT, with the model pointer nonzero beforehand.
        txn(4'b0010, 0, 0, -1);
        req = 4'b0100;
        step();
        chk_bus("rst_wr_pl", 1'b1, 3'd2, 16'h5678);
        for (int k = 0; k < 4; k++) step();
        chk_stat("rst_wait", 4'b0000, 1'b0, 1'b1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        req     = 4'b0000;
        chk_bus("mid_reset", 1'b0, 3'd0, 16'h0000);
        chk_stat("mid_reset", 4'b0000, 1'b0, 1'b0);
        chk("mid_reset_grant", {30'd0, grant_idx}, 32'd0);
        m_rr   = 0;
        m_last = -1;
        txn(4'b0101, 0, 0, -1);
        idle_cycle(1'b0);
        txn(4'b0100, 1, 0, -1);

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 4; i++) begin
                set_per(i, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            end
            txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 2)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
            if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
